// File: rtl/shift_reg4_sched.sv
// shift_reg4_sched: round-robin scheduler and sequencer for a 4-bit
// parallel-load shift register (shift_reg4, instantiated alongside).
// A granted word is loaded through set/d. It then leaves MSB-first on
// tx_bit under a valid/ready handshake. During a stall the register
// contents are recirculated.
//
// Ports:
//   clk, reset          clock, async active-low reset
//   req0/1, data0/1     word requests (held until granted) and their data
//   gnt0/1              combinational one-cycle grants
//   sr_set, sr_d        shift_reg4 control: 1 = load d, 0 = shift
//   sr_sin              shift_reg4 serial input, constant FILL
//   sr_q                shift_reg4 contents
//   tx_valid/ready      serial handshake; tx_bit = sr_q[3]
//   tx_last             current bit is bit 0 of the word
//   busy                FSM in SHIFT
//   words_sent          completed-word counter (wraps)
`timescale 1ns/1ps
module shift_reg4_sched #(
  parameter logic        FILL  = 1'b0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       data0,
  input  logic [3:0]       data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sr_set,
  output logic [3:0]       sr_d,
  output logic             sr_sin,
  input  logic [3:0]       sr_q,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_bit,
  output logic             tx_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] words_q, words_d;

  logic any_req;
  logic pick1;
  logic accept;

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rr_q    <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      words_q <= words_d;
    end
  end

  // Next-state, arbitration and shift-register control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    words_d  = words_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    sr_set   = 1'b0;
    sr_d     = 4'h0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    accept   = 1'b0;

    any_req = req0 | req1;
    // Requester 1 wins when alone, or when both ask and rr favours it
    pick1   = req1 & (~req0 | rr_q);

    case (state_q)
      IDLE: begin
        accept = any_req;
      end
      SHIFT: begin
        tx_valid = 1'b1;
        tx_last  = (cnt_q == 2'd3);
        if (!tx_ready) begin
          // Stall: reload the current contents so the register holds
          sr_set = 1'b1;
          sr_d   = sr_q;
        end else if (cnt_q != 2'd3) begin
          cnt_d = cnt_q + 2'd1;
        end else begin
          words_d = words_q + CNT_W'(1);
          if (any_req) begin
            accept = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset gating keeps grants quiet while reset is held with requests up
    if (accept && reset) begin
      gnt0    = ~pick1;
      gnt1    = pick1;
      sr_set  = 1'b1;
      sr_d    = pick1 ? data1 : data0;
      state_d = SHIFT;
      cnt_d   = 2'd0;
      rr_d    = ~pick1;
    end
  end

  assign sr_sin     = FILL;
  assign tx_bit     = sr_q[3];
  assign busy       = (state_q == SHIFT);
  assign words_sent = words_q;

endmodule
